// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier (control FSM + datapath).
// Holds the default operand width, the iteration-counter width helper and
// the control state encoding so both sides agree on them.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Counter must reach WIDTH itself, hence one bit beyond clog2.
  function automatic int cw(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CHECK = 2'd1,
    ST_ADD   = 2'd2,
    ST_SHIFT = 2'd3
  } mult_state_e;

endpackage

// File: rtl/iteration_counter.sv
// Iteration counter for the shift-add multiplier.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   write_i           counter write enable
//   increment_i       1 = increment (saturating at WIDTH), 0 = clear
//   finished_o        count == WIDTH (decoded from the register)
module iteration_counter
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic write_i,
  input  logic increment_i,
  output logic finished_o
);

  localparam int CW = cw(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (write_i) begin
      if (!increment_i)
        cnt_d = '0;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign finished_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/multiplier_datapath.sv
// Registered datapath of the sequential shift-add multiplier. Executes the
// control FSM's strobes verbatim; no sequencing of its own.
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   multiplicand, multiplier        operands, sampled on an initial load
//   select_initial/add/shift        product update select (priority in order)
//   select_counter_increment        counter source: 1 = increment, 0 = clear
//   write_product, write_counter    register write enables
//   finished                        iteration counter == WIDTH
//   product0                        LSB of the product register
//   product                         product register without the carry bit
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               select_initial,
  input  logic               select_add,
  input  logic               select_shift,
  input  logic               select_counter_increment,
  input  logic               write_product,
  input  logic               write_counter,
  output logic               finished,
  output logic               product0,
  output logic [2*WIDTH-1:0] product
);

  // P = {carry, high half, low half}
  logic [2*WIDTH:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   sum;

  // Carry out of the high-half add lands in the top bit of P.
  assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};

  always_comb begin
    p_d = p_q;
    m_d = m_q;
    if (write_product) begin
      if (select_initial) begin
        p_d = {1'b0, {WIDTH{1'b0}}, multiplier};
        m_d = multiplicand;
      end else if (select_add) begin
        p_d = {sum, p_q[WIDTH-1:0]};
      end else if (select_shift) begin
        p_d = p_q >> 1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q <= '0;
      m_q <= '0;
    end else begin
      p_q <= p_d;
      m_q <= m_d;
    end
  end

  iteration_counter #(.WIDTH(WIDTH)) u_counter (
    .clock       (clock),
    .reset       (reset),
    .write_i     (write_counter),
    .increment_i (select_counter_increment),
    .finished_o  (finished)
  );

  assign product0 = p_q[0];
  assign product  = p_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath.sv
module tb_multiplier_datapath;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   multiplicand, multiplier;
  logic           select_initial, select_add, select_shift;
  logic           select_counter_increment, write_product, write_counter;
  logic           finished, product0;
  logic [2*W-1:0] product;

  multiplier_datapath #(.WIDTH(W)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .multiplicand             (multiplicand),
    .multiplier               (multiplier),
    .select_initial           (select_initial),
    .select_add               (select_add),
    .select_shift             (select_shift),
    .select_counter_increment (select_counter_increment),
    .write_product            (write_product),
    .write_counter            (write_counter),
    .finished                 (finished),
    .product0                 (product0),
    .product                  (product)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit             chk_prod;
    logic           fin;
    logic [2*W-1:0] prod;
    string          name;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic idle();
    select_initial = 0; select_add = 0; select_shift = 0;
    select_counter_increment = 0; write_product = 0; write_counter = 0;
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Pop one scoreboard entry and compare against the DUT outputs now.
  task automatic drain();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (finished !== e.fin) begin
      bad++;
      $display("FAIL %s.finished: got %b want %b", e.name, finished, e.fin);
    end
    if (e.chk_prod) begin
      total++;
      if (product !== e.prod) begin
        bad++;
        $display("FAIL %s.product: got %h want %h", e.name, product, e.prod);
      end
    end
  endtask

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a; multiplier = b;
    select_initial = 1; write_product = 1; write_counter = 1;
    select_counter_increment = 0;
    cyc(); idle();
  endtask

  // FSM-order strobes: CHECK -> (ADD) -> SHIFT+increment, WIDTH times.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    logic [2*W-1:0] want;
    want = (2*W)'(a) * (2*W)'(b);
    do_load(a, b);
    for (int i = 0; i < W; i++) begin
      total++;
      if (product0 !== b[i]) begin
        bad++;
        $display("FAIL %s.product0[%0d]: got %b want %b", nm, i, product0, b[i]);
      end
      if (b[i]) begin
        select_add = 1; write_product = 1;
        cyc(); idle();
      end
      select_shift = 1; write_product = 1; write_counter = 1;
      select_counter_increment = 1;
      sb_q.push_back('{(i == W-1), (i == W-1), want, $sformatf("%s.it%0d", nm, i)});
      cyc(); idle();
      drain();
    end
  endtask

  task automatic test_reset();
    reset = 1; idle(); multiplicand = 0; multiplier = 0;
    cyc(); cyc();
    reset = 0;
    sb_q.push_back('{1, 1'b0, 8'h00, "reset_release"});
    cyc(); drain();
    // load something, then assert reset between edges
    do_load(4'd3, 4'd5);
    #2 reset = 1;
    #1;
    total++;
    if (product !== 8'h00 || product0 !== 1'b0 || finished !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got p=%h p0=%b fin=%b want p=00 p0=0 fin=0",
               product, product0, finished);
    end
    @(negedge clock); reset = 0;
    cyc();
  endtask

  task automatic test_load();
    do_load(4'd3, 4'd5);
    total++;
    if (product !== 8'h05 || product0 !== 1'b1 || finished !== 1'b0) begin
      bad++;
      $display("FAIL load: got p=%h p0=%b fin=%b want p=05 p0=1 fin=0",
               product, product0, finished);
    end
  endtask

  task automatic test_hold();
    do_load(4'd3, 4'd5);
    // select without write enable: no change
    select_add = 1; select_shift = 1;
    sb_q.push_back('{1, 1'b0, 8'h05, "hold_nowe"});
    cyc(); idle(); drain();
    // write enable with no select: P holds, counter still increments
    write_product = 1; write_counter = 1; select_counter_increment = 1;
    sb_q.push_back('{1, 1'b0, 8'h05, "hold_nosel"});
    cyc(); idle(); drain();
  endtask

  task automatic test_multiply();
    run_mult(4'd3, 4'd5, "m3x5");
    run_mult(4'd15, 4'd15, "m15x15");
  endtask

  task automatic test_saturate();
    // continues from 15x15 finished state
    for (int k = 0; k < 2; k++) begin
      select_shift = 1; write_product = 1; write_counter = 1;
      select_counter_increment = 1;
      sb_q.push_back('{1, 1'b1, (k == 0) ? 8'h70 : 8'h38, $sformatf("sat%0d", k)});
      cyc(); idle(); drain();
    end
    write_counter = 1; select_counter_increment = 0;
    sb_q.push_back('{1, 1'b0, 8'h38, "clear"});
    cyc(); idle(); drain();
  endtask

  task automatic test_priority();
    multiplicand = 4'd3; multiplier = 4'd5;
    select_initial = 1; select_add = 1; select_shift = 1; write_product = 1;
    sb_q.push_back('{1, 1'b0, 8'h05, "priority"});
    cyc(); idle(); drain();
  endtask

  task automatic test_back_to_back();
    run_mult(4'd0, 4'd9, "m0x9");
    run_mult(4'd15, 4'd1, "m15x1");
    run_mult(4'd9, 4'd13, "m9x13");
    run_mult(4'd1, 4'd8, "m1x8");
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_multiply();
    test_saturate();
    test_priority();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/multiplier_datapath.md
# multiplier_datapath

Registered datapath for the sequential shift-add multiplier. Driven cycle by cycle by the multiplier control FSM's select/write strobes, it holds the multiplicand, the combined product/multiplier register and the iteration counter, and returns the `finished` and `product0` status bits the FSM branches on. It has no sequencing of its own and performs exactly what the strobes request.

## Interface
- `WIDTH`, 32, operand width in bits; must be ≥ 2.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `multiplicand`  in  WIDTH  unsigned operand A; sampled only on an initial load.
- `multiplier`  in  WIDTH  unsigned operand B; sampled only on an initial load.
- `select_initial`  in  1  initial-load select.
- `select_add`  in  1  add-multiplicand select.
- `select_shift`  in  1  right-shift select.
- `select_counter_increment`  in  1  counter source: 1 = increment, 0 = clear.
- `write_product`  in  1  product (and multiplicand) register write enable.
- `write_counter`  in  1  counter write enable.
- `finished`  out  1  counter == WIDTH.
- `product0`  out  1  LSB of product register.
- `product`  out  2·WIDTH  current product register, excluding the carry bit.

## Operation
- State:
  - P: 2·WIDTH+1 bits (carry bit at the top, high half, low half).
  - M: WIDTH-bit multiplicand.
  - C: CW = clog2(WIDTH)+1 bit counter.
- Product write occurs when `write_product`=1. Select priority is `select_initial` > `select_add` > `select_shift`.
  - Initial: P ← {0, WIDTH'0, `multiplier`}; M ← `multiplicand`.
  - Add: P[2W:W] ← P[2W-1:W] + M. The sum is WIDTH+1 bits and its carry goes to P[2W]. P[W-1:0] is unchanged.
  - Shift: P ← P >> 1, logical; P[2W] ← 0.
  - No select asserted: P holds.
- M changes only on an initial load. It holds otherwise.
- Counter write occurs when `write_counter`=1.
  - `select_counter_increment`=0: C ← 0.
  - `select_counter_increment`=1: C ← C+1, saturating at WIDTH (never wraps).
  - `write_counter`=0: C holds.
- Outputs:
  - `finished` = (C == WIDTH).
  - `product0` = P[0].
  - `product` = P[2W-1:0].
  - All three are decoded from registers only; there is no combinational input→output path.
- Arithmetic is unsigned only. After WIDTH add/shift iterations, `product` = A·B exactly, with no truncation.
- Reset asynchronously clears P, M and C. Resulting output values: `finished`=0, `product0`=0, `product`=0. Reset asserted mid-multiply aborts it immediately, without waiting for a clock edge.
- Write enable with no select: writes nothing to P, counter still obeys `write_counter`.

## Timing
- All register updates occur on the rising edge of `clock` in which the strobes are sampled. Results are visible on outputs after that edge, so the FSM sees status one cycle after issuing a strobe.
- Per-iteration cost is set by the FSM: CHECK→SHIFT takes 2 cycles; CHECK→ADD→SHIFT takes 3 cycles.
  - Total from reset release to `finished`=1: 1 + between 2·WIDTH and 3·WIDTH cycles.
- `finished` rises in the cycle after the WIDTH-th shift and stays high until the next counter clear or reset.
- Shift and counter increment strobed in the same cycle both take effect on that edge.
- Strobes arriving after `finished`=1 are still executed on P, while C stays saturated.

## Structure
- Shared package `multiplier_pkg` holds:
  - the default `WIDTH`;
  - the counter-width function CW(WIDTH);
  - the FSM state encoding (START/CHECK/ADD/SHIFT), so control and datapath agree.
- The natural sub-module is `iteration_counter`: clear/increment, saturating at WIDTH, with a `finished` compare, parameterised by WIDTH.
- The adder and shifter stay inline in `multiplier_datapath`.

## Test plan
All scenarios use WIDTH=4.
- Assert `reset` between clock edges → P, M, C = 0 immediately; `finished`=0, `product`=8'h00.
- Initial load A=3, B=5 (`select_initial`, `write_product`, `write_counter`, increment=0) → `product`=8'h05, `product0`=1, `finished`=0.
- Full FSM-order strobe sequence for 3×5 → after 4th shift `product`=8'h0F, `finished`=1.
- 15×15 → carry bit exercised on adds; final `product`=8'hE1.
- One extra shift+increment after `finished` → C stays 4, `finished` stays 1, `product`=8'h70 (from 8'hE1).
- `select_initial`+`select_add`+`write_product` together with A=3, B=5 → initial wins, `product`=8'h05.
